sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 102 ++++++++++
 tb/tb_sync_fifo_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow, and standard or first-word-fall-through reads.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1,
   parameter bit FWFT      = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       wr_en,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

   if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
      $error("sync_fifo_param: WIDTH must be >=1 and DEPTH a power of two >=2");
   if (AF_THRESH < 1 || AF_THRESH > DEPTH)
      $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1)
      $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d, underflow_q, underflow_d;
   logic             wr_acc, rd_acc;

   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // No bypass: acceptance looks only at the flags before the edge.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem[wr_ptr_q] <= data_in;
   end

   if (FWFT) begin : g_fwft
      assign data_out = mem[rd_ptr_q];
   end else begin : g_std
      logic [WIDTH-1:0] data_q, data_d;
      always_comb begin
         data_d = data_q;
         if (rd_acc) data_d = mem[rd_ptr_q];
      end
      always_ff @(posedge clk) begin
         if (rst) data_q <= '0;
         else     data_q <= data_d;
      end
      assign data_out = data_q;
   end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT instance
// share clock and reset; expected values are hand-computed per step.
module tb_sync_fifo_param;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_din, f_din;
   logic       s_wr, s_rd, f_wr, f_rd;
   logic [7:0] s_dout, f_dout;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [2:0] s_cnt, f_cnt;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)) u_std (
      .clk(clk), .rst(rst), .data_in(s_din), .wr_en(s_wr), .rd_en(s_rd),
      .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_udf));

   sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst(rst), .data_in(f_din), .wr_en(f_wr), .rd_en(f_rd),
      .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic s_step(input logic wr, input logic rd, input logic [7:0] d);
      s_wr = wr; s_rd = rd; s_din = d;
      tick();
   endtask

   task automatic f_step(input logic wr, input logic rd, input logic [7:0] d);
      f_wr = wr; f_rd = rd; f_din = d;
      tick();
   endtask

   initial begin
      rst = 1'b1; s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hFF;
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'hEE;
      tick();
      tick();
      rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
      // Reset state, with both enables held high across the reset edges
      chk("rst_empty", 32'(s_empty), 32'd1);
      chk("rst_full", 32'(s_full), 32'd0);
      chk("rst_count", 32'(s_cnt), 32'd0);
      chk("rst_ovf", 32'(s_ovf), 32'd0);
      chk("rst_udf", 32'(s_udf), 32'd0);
      chk("rst_dout", 32'(s_dout), 32'h00);
      chk("rst_ae", 32'(s_ae), 32'd1);
      chk("rst_af", 32'(s_af), 32'd0);
      chk("rst_f_empty", 32'(f_empty), 32'd1);

      // Fill / drain
      s_step(1, 0, 8'hA1);
      s_step(1, 0, 8'hA2);
      chk("fill2_count", 32'(s_cnt), 32'd2);
      chk("fill2_ae", 32'(s_ae), 32'd0);
      s_step(1, 0, 8'hA3);
      chk("fill3_af", 32'(s_af), 32'd1);
      chk("fill3_full", 32'(s_full), 32'd0);
      s_step(1, 0, 8'hA4);
      chk("fill_full", 32'(s_full), 32'd1);
      chk("fill_count", 32'(s_cnt), 32'd4);
      chk("fill_ovf_pre", 32'(s_ovf), 32'd0);
      s_step(1, 0, 8'hA5);
      chk("ovf_set", 32'(s_ovf), 32'd1);
      chk("ovf_count", 32'(s_cnt), 32'd4);
      s_step(0, 1, 8'h00);
      chk("drain_d0", 32'(s_dout), 32'hA1);
      s_step(0, 1, 8'h00);
      chk("drain_d1", 32'(s_dout), 32'hA2);
      s_step(0, 1, 8'h00);
      chk("drain_d2", 32'(s_dout), 32'hA3);
      s_step(0, 1, 8'h00);
      chk("drain_d3", 32'(s_dout), 32'hA4);
      chk("drain_empty", 32'(s_empty), 32'd1);
      s_step(0, 0, 8'h00);
      chk("drain_hold", 32'(s_dout), 32'hA4);

      // Wrap: leave pointers at 3, then write four words across the boundary
      for (int i = 0; i < 3; i++) s_step(1, 0, 8'(i + 1));
      for (int i = 0; i < 3; i++) s_step(0, 1, 8'h00);
      chk("wrap_pre_d", 32'(s_dout), 32'h03);
      for (int i = 0; i < 4; i++) s_step(1, 0, 8'(8'h10 + i));
      chk("wrap_full", 32'(s_full), 32'd1);
      for (int i = 0; i < 4; i++) begin
         s_step(0, 1, 8'h00);
         chk($sformatf("wrap_d%0d", i), 32'(s_dout), 32'(8'h10 + i));
      end
      chk("wrap_empty", 32'(s_empty), 32'd1);

      // Mid-operation reset discards contents and clears sticky flags
      s_step(1, 0, 8'h5A);
      rst = 1'b1; s_step(1, 1, 8'h5B);
      rst = 1'b0;
      chk("rst2_count", 32'(s_cnt), 32'd0);
      chk("rst2_ovf", 32'(s_ovf), 32'd0);
      chk("rst2_dout", 32'(s_dout), 32'h00);

      // Simultaneous read/write at count=2
      s_step(1, 0, 8'h20);
      s_step(1, 0, 8'h21);
      for (int i = 0; i < 5; i++) begin
         s_step(1, 1, 8'(8'h22 + i));
         chk($sformatf("sim_d%0d", i), 32'(s_dout), 32'(8'h20 + i));
         chk($sformatf("sim_c%0d", i), 32'(s_cnt), 32'd2);
      end
      s_step(1, 0, 8'h27);
      s_step(1, 0, 8'h28);
      chk("sim_full", 32'(s_full), 32'd1);
      chk("sim_ovf_pre", 32'(s_ovf), 32'd0);
      s_step(1, 1, 8'h99);
      chk("full_rw_count", 32'(s_cnt), 32'd3);
      chk("full_rw_ovf", 32'(s_ovf), 32'd1);
      chk("full_rw_d", 32'(s_dout), 32'h25);
      s_step(0, 1, 8'h00);
      chk("full_rw_d1", 32'(s_dout), 32'h26);
      s_step(0, 1, 8'h00);
      chk("full_rw_d2", 32'(s_dout), 32'h27);
      s_step(0, 1, 8'h00);
      chk("full_rw_d3", 32'(s_dout), 32'h28);
      chk("full_rw_empty", 32'(s_empty), 32'd1);
      chk("udf_pre", 32'(s_udf), 32'd0);

      // Read while empty with a concurrent write
      s_step(1, 1, 8'h77);
      chk("udf_set", 32'(s_udf), 32'd1);
      chk("udf_count", 32'(s_cnt), 32'd1);
      chk("udf_dout_hold", 32'(s_dout), 32'h28);
      s_step(0, 1, 8'h00);
      chk("udf_read", 32'(s_dout), 32'h77);
      chk("udf_sticky", 32'(s_udf), 32'd1);
      s_step(0, 0, 8'h00);

      // First-word-fall-through instance
      f_step(1, 0, 8'h55);
      f_wr = 1'b0;
      chk("fw_d0", 32'(f_dout), 32'h55);
      chk("fw_empty0", 32'(f_empty), 32'd0);
      chk("fw_ae1", 32'(f_ae), 32'd1);
      chk("fw_af1", 32'(f_af), 32'd0);
      tick();
      chk("fw_d0_hold", 32'(f_dout), 32'h55);
      f_step(1, 0, 8'h66);
      chk("fw_ae2", 32'(f_ae), 32'd0);
      chk("fw_af2", 32'(f_af), 32'd0);
      f_step(1, 0, 8'h77);
      chk("fw_af3", 32'(f_af), 32'd1);
      chk("fw_full3", 32'(f_full), 32'd0);
      chk("fw_head3", 32'(f_dout), 32'h55);
      f_step(0, 1, 8'h00);
      chk("fw_pop1", 32'(f_dout), 32'h66);
      chk("fw_cnt2", 32'(f_cnt), 32'd2);
      f_step(0, 1, 8'h00);
      chk("fw_pop2", 32'(f_dout), 32'h77);
      chk("fw_cnt1", 32'(f_cnt), 32'd1);
      f_step(1, 1, 8'h88);
      chk("fw_rw1_cnt", 32'(f_cnt), 32'd1);
      chk("fw_rw1_d", 32'(f_dout), 32'h88);
      f_step(0, 1, 8'h00);
      f_rd = 1'b0;
      chk("fw_empty", 32'(f_empty), 32'd1);
      chk("fw_udf", 32'(f_udf), 32'd0);
      chk("fw_ovf", 32'(f_ovf), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
